// File: rtl/arbiter4_rr_sync.sv
// Four-way round-robin arbiter for four-phase req/ack requesters sharing one upstream req/ack pair.
// Optional input synchronizers are enabled with `define ARB_SYNC_EN.
module arbiter4_rr_sync #(
  parameter int unsigned HOLD_MAX = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] ack,
  output logic       req_out,
  input  logic       ack_in,
  input  logic       err_clr,
  output logic       busy,
  output logic [1:0] grant_id,
  output logic       hold_err,
  output logic       proto_err
);

  localparam int unsigned CntW = $clog2(HOLD_MAX + 1);
  localparam logic [CntW-1:0] HoldMax   = CntW'(HOLD_MAX);
  localparam logic [CntW-1:0] HoldMaxM1 = CntW'(HOLD_MAX - 1);

  typedef enum logic [1:0] {StIdle, StWaitUp, StGrant, StWaitDn} state_e;

  state_e          state_q;
  logic [1:0]      ptr_q;
  logic [CntW-1:0] hold_cnt_q;
  logic            ready_q;
  logic [3:0]      req_s;
  logic            ack_in_s;
  logic            primed;

`ifdef ARB_SYNC_EN
  logic [4:0] sync1_q, sync2_q;
  logic [1:0] prime_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prime_q <= '0;
    end else begin
      sync1_q <= {ack_in, req};
      sync2_q <= sync1_q;
      prime_q <= {prime_q[0], 1'b1};
    end
  end

  assign req_s    = sync2_q[3:0];
  assign ack_in_s = sync2_q[4];
  // Reset zeros in the synchronizer must not be mistaken for a real low ack_in.
  assign primed   = prime_q[1];
`else
  assign req_s    = req;
  assign ack_in_s = ack_in;
  assign primed   = 1'b1;
`endif

  // Lowest index at or after p (cyclically) whose request is high.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= 2'd0;
      hold_cnt_q <= '0;
      ready_q    <= 1'b0;
      ack        <= 4'b0000;
      req_out    <= 1'b0;
      busy       <= 1'b0;
      grant_id   <= 2'd0;
      hold_err   <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      // A new upstream request needs ack_in seen low first, so no phase is skipped after reset.
      ready_q <= primed & ~ack_in_s;
      if (err_clr) begin
        hold_err  <= 1'b0;
        proto_err <= 1'b0;
      end
      case (state_q)
        StIdle: begin
          if (ready_q && (|req_s)) begin
            grant_id <= rr_pick(req_s, ptr_q);
            req_out  <= 1'b1;
            busy     <= 1'b1;
            state_q  <= StWaitUp;
          end
        end
        StWaitUp: begin
          if (!req_s[grant_id]) proto_err <= 1'b1;
          if (ack_in_s) begin
            ack        <= 4'b0001 << grant_id;
            hold_cnt_q <= '0;
            state_q    <= StGrant;
          end
        end
        StGrant: begin
          if (!req_s[grant_id]) begin
            ack     <= 4'b0000;
            req_out <= 1'b0;
            state_q <= StWaitDn;
          end else begin
            if (hold_cnt_q != HoldMax) hold_cnt_q <= hold_cnt_q + CntW'(1);
            // Fires once, on the edge the count reaches HOLD_MAX, so err_clr can still clear it.
            if (hold_cnt_q == HoldMaxM1) hold_err <= 1'b1;
          end
        end
        StWaitDn: begin
          if (!ack_in_s) begin
            ptr_q   <= grant_id + 2'd1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_arbiter4_rr_sync.sv
// Self-checking bench for arbiter4_rr_sync (default build, HOLD_MAX = 4).
// Expected grant winners are queued when requests are driven and popped when ack appears.
module tb_arbiter4_rr_sync;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] ack;
  logic       req_out;
  logic       ack_in;
  logic       err_clr;
  logic       busy;
  logic [1:0] grant_id;
  logic       hold_err;
  logic       proto_err;

  int n_cmp;
  int n_err;
  int sb[$];

  arbiter4_rr_sync #(.HOLD_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .ack       (ack),
    .req_out   (req_out),
    .ack_in    (ack_in),
    .err_clr   (err_clr),
    .busy      (busy),
    .grant_id  (grant_id),
    .hold_err  (hold_err),
    .proto_err (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    req     = 4'b0000;
    ack_in  = 1'b0;
    err_clr = 1'b0;
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Acts as upstream and as the winning requester for one full handshake.
  task automatic serve(input bit reraise);
    bit got;
    int w;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (req_out === 1'b1) got = 1'b1;
      else tick();
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL serve_req_out: got req_out=%b, want 1 within 20 cycles", req_out);
      return;
    end
    ack_in = 1'b1;
    tick();
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL serve_sb: got ack=%b, want a queued expected winner", ack);
      w = 0;
    end else begin
      w = sb.pop_front();
      if (ack !== (4'b0001 << w)) begin
        n_err++;
        $display("FAIL grant_order: got ack=%b, want %b", ack, 4'b0001 << w);
      end
    end
    req[w] = 1'b0;
    tick();
    n_cmp++;
    if (ack !== 4'b0000 || req_out !== 1'b0) begin
      n_err++;
      $display("FAIL release: got ack=%b req_out=%b, want 0000 0", ack, req_out);
    end
    if (reraise) req[w] = 1'b1;
    ack_in = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_return: got busy=%b, want 0", busy);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (ack !== 4'b0000) begin n_err++; $display("FAIL rst_ack: got %b, want 0000", ack); end
    n_cmp++; if (req_out !== 1'b0) begin n_err++; $display("FAIL rst_req_out: got %b, want 0", req_out); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b, want 0", busy); end
    n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL rst_gid: got %0d, want 0", grant_id); end
    n_cmp++; if (hold_err !== 1'b0) begin n_err++; $display("FAIL rst_hold: got %b, want 0", hold_err); end
    n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL rst_proto: got %b, want 0", proto_err); end
  endtask

  task automatic test_single();
    int w;
    do_reset();
    req = 4'b0001;
    sb.push_back(0);
    tick();
    n_cmp++;
    if (req_out !== 1'b1 || busy !== 1'b1 || grant_id !== 2'd0) begin
      n_err++;
      $display("FAIL single_up: got req_out=%b busy=%b gid=%0d, want 1 1 0", req_out, busy, grant_id);
    end
    tick();
    tick();
    n_cmp++;
    if (ack !== 4'b0000) begin n_err++; $display("FAIL single_noack: got %b, want 0000", ack); end
    ack_in = 1'b1;
    tick();
    w = sb.pop_front();
    n_cmp++;
    if (ack !== (4'b0001 << w)) begin
      n_err++;
      $display("FAIL single_ack: got %b, want %b", ack, 4'b0001 << w);
    end
    req = 4'b0000;
    tick();
    n_cmp++;
    if (ack !== 4'b0000 || req_out !== 1'b0) begin
      n_err++;
      $display("FAIL single_drop: got ack=%b req_out=%b, want 0000 0", ack, req_out);
    end
    ack_in = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle: got busy=%b, want 0", busy); end
    // ptr is now 1: with 0 and 1 both requesting, 1 wins, then 0.
    req = 4'b0011;
    sb.push_back(1);
    sb.push_back(0);
    serve(1'b0);
    serve(1'b0);
    req = 4'b0000;
  endtask

  task automatic test_contention();
    do_reset();
    req = 4'b1111;
    sb.push_back(0);
    sb.push_back(1);
    sb.push_back(2);
    sb.push_back(3);
    sb.push_back(0);
    for (int i = 0; i < 5; i++) serve(1'b1);
    req = 4'b0000;
  endtask

  task automatic test_ptr_wrap();
    do_reset();
    req = 4'b0100;
    sb.push_back(2);
    serve(1'b0);
    // ptr is now 3.
    req = 4'b1001;
    sb.push_back(3);
    sb.push_back(0);
    serve(1'b0);
    serve(1'b0);
    req = 4'b0000;
  endtask

  task automatic test_hold_timeout();
    do_reset();
    req = 4'b0010;
    tick();
    ack_in = 1'b1;
    tick();
    n_cmp++;
    if (ack !== 4'b0010) begin n_err++; $display("FAIL hold_ack: got %b, want 0010", ack); end
    // hold_err rises after the 4th edge spent in GRANT.
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_cmp++;
      if (hold_err !== 1'b0) begin
        n_err++;
        $display("FAIL hold_early: edge %0d got %b, want 0", i, hold_err);
      end
    end
    tick();
    n_cmp++;
    if (hold_err !== 1'b1 || ack !== 4'b0010) begin
      n_err++;
      $display("FAIL hold_set: got hold_err=%b ack=%b, want 1 0010", hold_err, ack);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_cmp++;
    if (hold_err !== 1'b0) begin n_err++; $display("FAIL hold_clr: got %b, want 0", hold_err); end
    tick();
    n_cmp++;
    if (hold_err !== 1'b0 || ack !== 4'b0010) begin
      n_err++;
      $display("FAIL hold_after: got hold_err=%b ack=%b, want 0 0010", hold_err, ack);
    end
    req = 4'b0000;
    tick();
    ack_in = 1'b0;
    tick();
  endtask

  task automatic test_proto_err();
    do_reset();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    tick();
    n_cmp++;
    if (proto_err !== 1'b1 || ack !== 4'b0000) begin
      n_err++;
      $display("FAIL proto_set: got proto_err=%b ack=%b, want 1 0000", proto_err, ack);
    end
    ack_in = 1'b1;
    tick();
    n_cmp++;
    if (ack !== 4'b0100) begin n_err++; $display("FAIL proto_pulse: got %b, want 0100", ack); end
    tick();
    n_cmp++;
    if (ack !== 4'b0000 || req_out !== 1'b0) begin
      n_err++;
      $display("FAIL proto_one_cycle: got ack=%b req_out=%b, want 0000 0", ack, req_out);
    end
    ack_in = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || proto_err !== 1'b1) begin
      n_err++;
      $display("FAIL proto_idle: got busy=%b proto_err=%b, want 0 1", busy, proto_err);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_cmp++;
    if (proto_err !== 1'b0) begin n_err++; $display("FAIL proto_clr: got %b, want 0", proto_err); end
  endtask

  task automatic test_reset_mid_grant();
    bit bad;
    do_reset();
    req = 4'b0100;
    tick();
    ack_in = 1'b1;
    tick();
    n_cmp++;
    if (ack !== 4'b0100 || grant_id !== 2'd2) begin
      n_err++;
      $display("FAIL mid_grant: got ack=%b gid=%0d, want 0100 2", ack, grant_id);
    end
    #2;
    rst_n = 1'b0;
    req   = 4'b0001;
    #1;
    n_cmp++;
    if (ack !== 4'b0000 || req_out !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd0) begin
      n_err++;
      $display("FAIL mid_async: got ack=%b req_out=%b busy=%b gid=%0d, want 0000 0 0 0",
               ack, req_out, busy, grant_id);
    end
    tick();
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (req_out !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin n_err++; $display("FAIL mid_hold_low: got req_out=1, want 0 while ack_in=1"); end
    ack_in = 1'b0;
    tick();
    n_cmp++;
    if (req_out !== 1'b0) begin n_err++; $display("FAIL mid_no_early: got %b, want 0", req_out); end
    tick();
    n_cmp++;
    if (req_out !== 1'b1 || grant_id !== 2'd0) begin
      n_err++;
      $display("FAIL mid_rise: got req_out=%b gid=%0d, want 1 0", req_out, grant_id);
    end
    sb.push_back(0);
    serve(1'b0);
    req = 4'b0000;
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    req     = 4'b0000;
    ack_in  = 1'b0;
    err_clr = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_ptr_wrap();
    test_hold_timeout();
    test_proto_err();
    test_reset_mid_grant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
